pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  pipeline clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 UseShamt, UseImmed  in  1 each  ID instruction does not read Rs / does not read Rt as an ALU operand.
REQ-007 ID_Jump, ID_Branch  in  1 each  ID holds an unconditional jump / a conditional branch.
REQ-008 EX_Rw  in  5  destination register number of the instruction in EX.
REQ-009 EX_MemRead  in  1  EX instruction is a load.
REQ-010 EX_BranchTaken  in  1  branch in EX resolved taken; valid only in state BRANCH_WAIT.
REQ-011 StallCntClr  in  1  clears StallCount.
REQ-012 PC_Write  out  1  PC register load enable.
REQ-013 AddrSel  out  2  next-PC select: 00 = PC+4, 01 = jump target, 10 = branch target; 11 is never driven.
REQ-014 IF_ID_Write  out  1  IF/ID register load enable.
REQ-015 IF_ID_Flush  out  1  load a NOP into IF/ID instead of the fetched word; overrides IF_ID_Write.
REQ-016 Bubble  out  1  zero the ID/EX control fields.
REQ-017 StallCount  out  CNT_W  saturating count of cycles with PC_Write = 0.
REQ-018 DbgState  out  1  current state: 0 = NORMAL, 1 = BRANCH_WAIT.

Function
REQ-019 LoadUse SHALL be defined as: EX_MemRead and EX_Rw != 0 and ((ID_Rs == EX_Rw and !UseShamt) or (ID_Rt == EX_Rw and !UseImmed)).
REQ-020 Default outputs SHALL be: PC_Write = 1, AddrSel = 00, IF_ID_Write = 1, IF_ID_Flush = 0, Bubble = 0.
REQ-021 Outputs SHALL be Mealy: a combinational function of the state and the current inputs, with zero-cycle latency.
REQ-022 Priority in NORMAL SHALL be: LoadUse, then ID_Jump, then ID_Branch.
REQ-023 NORMAL with LoadUse: PC_Write = 0, IF_ID_Write = 0, Bubble = 1; next state NORMAL, giving exactly one bubble.
REQ-024 NORMAL with ID_Jump and no LoadUse: AddrSel = 01, IF_ID_Flush = 1; next state NORMAL.
REQ-025 NORMAL with ID_Branch and no LoadUse or jump: PC_Write = 0, IF_ID_Flush = 1, Bubble = 0, so the branch advances to EX; next state BRANCH_WAIT.
REQ-026 BRANCH_WAIT SHALL ignore all ID_* inputs and LoadUse, because ID holds the flushed NOP.
REQ-027 BRANCH_WAIT with EX_BranchTaken = 1: AddrSel = 10, PC_Write = 1, IF_ID_Flush = 1.
REQ-028 BRANCH_WAIT with EX_BranchTaken = 0: default outputs.
REQ-029 BRANCH_WAIT SHALL always move to NORMAL after one cycle.
REQ-030 EX_BranchTaken SHALL be ignored in NORMAL.
REQ-031 StallCount SHALL increment by 1 on each cycle with PC_Write = 0, saturate at all-ones, and never wrap.
REQ-032 StallCntClr SHALL set StallCount to 0 on the next edge; when a stall occurs in the same cycle, the result is 0 (clear wins).
REQ-033 The ID_Jump and ID_Branch inputs SHALL never both be 1; if they are, the jump is taken.

Reset
REQ-034 Reset SHALL set the state to NORMAL and StallCount to 0 on the next CLK edge.
REQ-035 While Reset = 1, outputs SHALL be forced to: PC_Write = 0, IF_ID_Write = 0, IF_ID_Flush = 1, Bubble = 1, AddrSel = 00.
REQ-036 Reset asserted in BRANCH_WAIT SHALL abandon the branch, with no AddrSel = 10 issued.
REQ-037 StallCount SHALL NOT increment during cycles with Reset = 1.

Verification
REQ-038 Load-use: EX_MemRead = 1, EX_Rw = 5, ID_Rs = 5, UseShamt = 0 -> PC_Write = 0, IF_ID_Write = 0, Bubble = 1 for one cycle, StallCount 0 -> 1; with EX_Rw = 0 instead -> no stall.
REQ-039 Immediate masking: EX_MemRead = 1, EX_Rw = 7, ID_Rt = 7, UseImmed = 1, ID_Rs = 3 -> default outputs.
REQ-040 Taken branch: ID_Branch = 1 -> cycle 1: PC_Write = 0, IF_ID_Flush = 1, DbgState -> 1; cycle 2 with EX_BranchTaken = 1 -> AddrSel = 10, IF_ID_Flush = 1, DbgState -> 0; repeat with EX_BranchTaken = 0 -> AddrSel = 00, no flush.
REQ-041 Priority: LoadUse, ID_Jump and ID_Branch all 1 -> stall outputs only, AddrSel = 00, DbgState stays 0; next cycle with LoadUse = 0 -> jump taken (AddrSel = 01).
REQ-042 Saturation and clear: CNT_W = 4, 20 consecutive load-use cycles -> StallCount holds at 15; StallCntClr = 1 together with a stall -> StallCount = 0.
REQ-043 Reset mid-branch: Reset = 1 in BRANCH_WAIT with EX_BranchTaken = 1 -> AddrSel = 00, PC_Write = 0, next DbgState = 0, StallCount = 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard control unit for a classic five-stage in-order pipeline. It
// watches the instruction in ID and the instruction in EX and decides
// whether to stall fetch, insert a bubble, flush IF/ID, or redirect the PC
// to a jump or branch target.
//
// Control outputs are Mealy: they react to the current inputs in the same
// cycle. The only state is a one-bit phase register (NORMAL / BRANCH_WAIT)
// and a saturating counter of stalled cycles.
//
// Ports
//   CLK            in   pipeline clock, rising-edge active
//   Reset          in   synchronous active-high reset
//   ID_Rs, ID_Rt   in   source register numbers of the ID instruction
//   UseShamt       in   ID instruction does not read Rs as an ALU operand
//   UseImmed       in   ID instruction does not read Rt as an ALU operand
//   ID_Jump        in   ID holds an unconditional jump
//   ID_Branch      in   ID holds a conditional branch
//   EX_Rw          in   destination register of the EX instruction
//   EX_MemRead     in   EX instruction is a load
//   EX_BranchTaken in   branch in EX resolved taken (used in BRANCH_WAIT)
//   StallCntClr    in   clear the stall counter on the next edge
//   PC_Write       out  PC load enable
//   AddrSel        out  next-PC select: 00 PC+4, 01 jump, 10 branch
//   IF_ID_Write    out  IF/ID load enable
//   IF_ID_Flush    out  load a NOP into IF/ID (overrides IF_ID_Write)
//   Bubble         out  zero the ID/EX control fields
//   StallCount     out  saturating count of cycles with PC_Write = 0
//   DbgState       out  current phase: 0 NORMAL, 1 BRANCH_WAIT
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             UseShamt,
    input  logic             UseImmed,
    input  logic             ID_Jump,
    input  logic             ID_Branch,
    input  logic [4:0]       EX_Rw,
    input  logic             EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             StallCntClr,
    output logic             PC_Write,
    output logic [1:0]       AddrSel,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Bubble,
    output logic [CNT_W-1:0] StallCount,
    output logic             DbgState
);

    typedef enum logic {
        NORMAL      = 1'b0,
        BRANCH_WAIT = 1'b1
    } state_e;

    localparam logic [1:0]       SEL_PC4    = 2'b00;
    localparam logic [1:0]       SEL_JUMP   = 2'b01;
    localparam logic [1:0]       SEL_BRANCH = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             load_use_s;

    // A load writing r0 never creates a dependency, and an operand that is
    // replaced by shamt/immediate is not actually read by the ALU.
    function automatic logic detect_load_use(
        input logic       mem_read,
        input logic [4:0] rw,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_shamt,
        input logic       use_immed
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = (rs == rw) && !use_shamt;
        rt_hit = (rt == rw) && !use_immed;
        return mem_read && (rw != 5'd0) && (rs_hit || rt_hit);
    endfunction

    // Load-use hazard between the instruction in ID and the load in EX.
    always_comb begin
        load_use_s = detect_load_use(EX_MemRead, EX_Rw, ID_Rs, ID_Rt,
                                     UseShamt, UseImmed);
    end

    // Mealy control outputs and next phase.
    always_comb begin
        PC_Write    = 1'b1;
        AddrSel     = SEL_PC4;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        Bubble      = 1'b0;
        state_d     = state_q;

        if (Reset) begin
            // Freeze fetch and drain the front end; any pending branch in
            // BRANCH_WAIT is dropped without redirecting the PC.
            PC_Write    = 1'b0;
            AddrSel     = SEL_PC4;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            Bubble      = 1'b1;
            state_d     = NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (load_use_s) begin
                        // Hold PC and IF/ID for one cycle and inject a bubble;
                        // next cycle the load has left EX so the hazard clears.
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        Bubble      = 1'b1;
                        state_d     = NORMAL;
                    end else if (ID_Jump) begin
                        // Jump also wins if ID_Branch is asserted alongside.
                        AddrSel     = SEL_JUMP;
                        IF_ID_Flush = 1'b1;
                        state_d     = NORMAL;
                    end else if (ID_Branch) begin
                        // Let the branch move into EX to resolve, hold the PC
                        // and squash the sequentially fetched word.
                        PC_Write    = 1'b0;
                        IF_ID_Flush = 1'b1;
                        state_d     = BRANCH_WAIT;
                    end else begin
                        state_d     = NORMAL;
                    end
                end
                BRANCH_WAIT: begin
                    // ID holds the squashed NOP here, so only the EX branch
                    // outcome matters.
                    if (EX_BranchTaken) begin
                        PC_Write    = 1'b1;
                        AddrSel     = SEL_BRANCH;
                        IF_ID_Flush = 1'b1;
                    end else begin
                        PC_Write    = 1'b1;
                        AddrSel     = SEL_PC4;
                    end
                    state_d = NORMAL;
                end
                default: begin
                    state_d = NORMAL;
                end
            endcase
        end
    end

    // Stall counter next value: clear has priority over a stall, reset
    // cycles never count, and the counter sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Reset) begin
            stall_cnt_d = '0;
        end else if (StallCntClr) begin
            stall_cnt_d = '0;
        end else if (!PC_Write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Phase and stall-counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= NORMAL;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for pipeline_hazard_controller (CNT_W = 4).
// Stimulus drives one directed vector per cycle just after the rising edge
// and pushes the hand-computed expected outputs, phase and counter; a
// monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    logic       CLK;
    logic       Reset;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       UseShamt;
    logic       UseImmed;
    logic       ID_Jump;
    logic       ID_Branch;
    logic [4:0] EX_Rw;
    logic       EX_MemRead;
    logic       EX_BranchTaken;
    logic       StallCntClr;
    logic       PC_Write;
    logic [1:0] AddrSel;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       Bubble;
    logic [3:0] StallCount;
    logic       DbgState;

    pipeline_hazard_controller #(.CNT_W(4)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .UseShamt       (UseShamt),
        .UseImmed       (UseImmed),
        .ID_Jump        (ID_Jump),
        .ID_Branch      (ID_Branch),
        .EX_Rw          (EX_Rw),
        .EX_MemRead     (EX_MemRead),
        .EX_BranchTaken (EX_BranchTaken),
        .StallCntClr    (StallCntClr),
        .PC_Write       (PC_Write),
        .AddrSel        (AddrSel),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .Bubble         (Bubble),
        .StallCount     (StallCount),
        .DbgState       (DbgState)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {PC_Write, AddrSel, IF_ID_Write, IF_ID_Flush, Bubble}
    typedef struct packed {
        logic [5:0] ctl;
        logic       dbg;
        logic [3:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    stim_done = 1'b0;

    localparam logic [5:0] C_DEF   = 6'b1_00_1_0_0;
    localparam logic [5:0] C_STALL = 6'b0_00_0_0_1;
    localparam logic [5:0] C_JUMP  = 6'b1_01_1_1_0;
    localparam logic [5:0] C_BR    = 6'b0_00_1_1_0;
    localparam logic [5:0] C_TAKEN = 6'b1_10_1_1_0;
    localparam logic [5:0] C_RST   = 6'b0_00_0_1_1;

    // Monitor: compare the DUT against the oldest expected entry each cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [5:0] act;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {PC_Write, AddrSel, IF_ID_Write, IF_ID_Flush, Bubble};
            n_checks++;
            if (act !== e.ctl) begin
                n_errors++;
                $display("FAIL %s ctl: got %b expected %b", nm, act, e.ctl);
            end
            n_checks++;
            if (DbgState !== e.dbg) begin
                n_errors++;
                $display("FAIL %s DbgState: got %b expected %b", nm, DbgState, e.dbg);
            end
            n_checks++;
            if (StallCount !== e.cnt) begin
                n_errors++;
                $display("FAIL %s StallCount: got %0d expected %0d", nm, StallCount, e.cnt);
            end
        end
    end

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; UseShamt = 1'b0; UseImmed = 1'b0;
        ID_Jump = 1'b0; ID_Branch = 1'b0; EX_Rw = 5'd0; EX_MemRead = 1'b0;
        EX_BranchTaken = 1'b0; StallCntClr = 1'b0;
    endtask

    task automatic load_use();
        EX_MemRead = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5; UseShamt = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, then advance a cycle.
    task automatic chk(input string nm, input logic [5:0] ctl,
                       input logic dbg, input logic [3:0] cnt);
        exp_t e;
        e.ctl = ctl; e.dbg = dbg; e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset", C_RST, 1'b0, 4'd0);
        Reset = 1'b0;

        idle();                                   chk("idle", C_DEF, 1'b0, 4'd0);
        idle(); load_use();                       chk("loaduse_rs", C_STALL, 1'b0, 4'd0);
        idle();                                   chk("after_stall", C_DEF, 1'b0, 4'd1);
        idle(); EX_MemRead = 1'b1;                chk("rw_zero", C_DEF, 1'b0, 4'd1);
        idle(); EX_MemRead = 1'b1; EX_Rw = 5'd7; ID_Rt = 5'd7; UseImmed = 1'b1; ID_Rs = 5'd3;
                                                  chk("immed_mask", C_DEF, 1'b0, 4'd1);
        idle(); EX_MemRead = 1'b1; EX_Rw = 5'd9; ID_Rs = 5'd9; UseShamt = 1'b1; ID_Rt = 5'd2;
                                                  chk("shamt_mask", C_DEF, 1'b0, 4'd1);
        idle(); EX_MemRead = 1'b1; EX_Rw = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd1;
                                                  chk("loaduse_rt", C_STALL, 1'b0, 4'd1);
        idle(); ID_Jump = 1'b1;                   chk("jump", C_JUMP, 1'b0, 4'd2);
        idle(); ID_Branch = 1'b1;                 chk("branch1", C_BR, 1'b0, 4'd2);
        idle(); EX_BranchTaken = 1'b1; ID_Jump = 1'b1; load_use();
                                                  chk("bw_taken", C_TAKEN, 1'b1, 4'd3);
        idle(); ID_Branch = 1'b1;                 chk("branch2", C_BR, 1'b0, 4'd3);
        idle(); load_use();                       chk("bw_not_taken", C_DEF, 1'b1, 4'd4);
        idle(); EX_BranchTaken = 1'b1;            chk("taken_in_normal", C_DEF, 1'b0, 4'd4);
        idle(); load_use(); ID_Jump = 1'b1; ID_Branch = 1'b1;
                                                  chk("prio_all", C_STALL, 1'b0, 4'd4);
        idle(); ID_Jump = 1'b1; ID_Branch = 1'b1; chk("prio_jump", C_JUMP, 1'b0, 4'd5);
        idle();                                   chk("after_prio", C_DEF, 1'b0, 4'd5);

        for (int i = 0; i < 20; i++) begin
            idle(); load_use();
            chk("saturate", C_STALL, 1'b0, (5 + i > 15) ? 4'd15 : 4'(5 + i));
        end
        idle();                                   chk("sat_hold", C_DEF, 1'b0, 4'd15);
        idle(); load_use(); StallCntClr = 1'b1;   chk("clr_with_stall", C_STALL, 1'b0, 4'd15);
        idle();                                   chk("after_clr", C_DEF, 1'b0, 4'd0);

        idle(); ID_Branch = 1'b1;                 chk("branch3", C_BR, 1'b0, 4'd0);
        idle(); EX_BranchTaken = 1'b1; Reset = 1'b1;
                                                  chk("reset_in_bw", C_RST, 1'b1, 4'd1);
        idle(); load_use(); Reset = 1'b1;         chk("reset_no_count", C_RST, 1'b0, 4'd0);
        idle(); Reset = 1'b0;                     chk("post_reset", C_DEF, 1'b0, 4'd0);
        idle();                                   chk("final", C_DEF, 1'b0, 4'd0);

        stim_done = 1'b1;
    end

    // End of run: drain the scoreboard (bounded) and print the summary.
    initial begin
        int waited;
        waited = 0;
        while (!stim_done && waited < 2000) begin
            @(posedge CLK);
            waited++;
        end
        repeat (2) @(posedge CLK);
        n_checks++;
        if (!stim_done || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: stim_done=%0d pending=%0d expected 1 and 0",
                     stim_done, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
